// File: rtl/nbit_pipe_register.sv
// nbit_pipe_register
//
// Multi-stage register slice with valid/ready flow control. A REG_WIDTH-bit payload moves
// through STAGES register stages at full throughput. The ready chain is combinational, so a
// bubble anywhere in the pipe is collapsed in the same cycle. The number of occupied stages
// is reported on count.
//
// Optional feature macro: NBIT_PIPE_FLUSH_EN adds a synchronous flush input. A flush clears
// every valid bit and blocks input for that cycle. Payload registers are left unchanged.
//
// Parameters:
//   REG_WIDTH  payload width in bits (>= 1)
//   STAGES     number of register stages (>= 1), equal to the unstalled latency
//   CNT_W      derived width of the occupancy count
//
// Ports:
//   ACLK       clock, rising edge
//   RST        asynchronous active-high reset
//   in_valid   upstream word valid
//   in_ready   slice accepts a word this cycle
//   in_data    upstream payload
//   out_valid  last stage holds a word
//   out_ready  downstream accepts the word this cycle
//   out_data   payload of the last stage
//   count      number of valid stages (0..STAGES)
//   flush      synchronous discard of all words (NBIT_PIPE_FLUSH_EN only)

module nbit_pipe_register #(
    parameter int unsigned REG_WIDTH = 32,
    parameter int unsigned STAGES    = 2,
    localparam int unsigned CNT_W    = $clog2(STAGES + 1)
) (
    input  logic                 ACLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REG_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]     count
`ifdef NBIT_PIPE_FLUSH_EN
    ,
    input  logic                 flush
`endif
);

    logic [STAGES-1:0]    v_q, v_d;
    logic [REG_WIDTH-1:0] d_q [STAGES];
    logic [REG_WIDTH-1:0] d_d [STAGES];
    logic [CNT_W-1:0]     count_q, count_d;
    logic [STAGES-1:0]    rdy;

    // A stage is ready unless it and every stage downstream of it are full while the output
    // stalls. Computing it from the full-tail keeps the chain free of a vector self-loop.
    always_comb begin : ready_chain
        logic tail_full;
        tail_full = 1'b1;
        rdy       = '0;
        for (int i = int'(STAGES) - 1; i >= 0; i--) begin
            tail_full = tail_full & v_q[i];
            rdy[i]    = ~tail_full | out_ready;
        end
    end

    always_comb begin
        v_d = v_q;
        d_d = d_q;

        if (rdy[0]) begin
            v_d[0] = in_valid;
            // Payload only captured with a valid word, so bubbles do not toggle data.
            if (in_valid) begin
                d_d[0] = in_data;
            end
        end

        for (int i = 1; i < int'(STAGES); i++) begin
            if (rdy[i]) begin
                v_d[i] = v_q[i-1];
                if (v_q[i-1]) begin
                    d_d[i] = d_q[i-1];
                end
            end
        end

`ifdef NBIT_PIPE_FLUSH_EN
        // Flush wins over any transfer; payload is intentionally preserved.
        if (flush) begin
            v_d = '0;
            d_d = d_q;
        end
`endif

        count_d = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            count_d = count_d + CNT_W'(v_d[i]);
        end
    end

    always_ff @(posedge ACLK or posedge RST) begin
        if (RST) begin
            v_q     <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                d_q[i] <= '0;
            end
        end else begin
            v_q     <= v_d;
            count_q <= count_d;
            for (int i = 0; i < int'(STAGES); i++) begin
                d_q[i] <= d_d[i];
            end
        end
    end

`ifdef NBIT_PIPE_FLUSH_EN
    assign in_ready = rdy[0] & ~flush;
`else
    assign in_ready = rdy[0];
`endif
    assign out_valid = v_q[STAGES-1];
    assign out_data  = d_q[STAGES-1];
    assign count     = count_q;

endmodule

// File: tb/tb_nbit_pipe_register.sv
// Self-checking bench for nbit_pipe_register with REG_WIDTH=32, STAGES=3.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.

module tb_nbit_pipe_register;

    localparam int unsigned W     = 32;
    localparam int unsigned ST    = 3;
    localparam int unsigned CNT_W = $clog2(ST + 1);

    logic             ACLK;
    logic             RST;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [CNT_W-1:0] count;
`ifdef NBIT_PIPE_FLUSH_EN
    logic             flush;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    nbit_pipe_register #(
        .REG_WIDTH(W),
        .STAGES   (ST)
    ) dut (
        .ACLK     (ACLK),
        .RST      (RST),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count)
`ifdef NBIT_PIPE_FLUSH_EN
        ,
        .flush    (flush)
`endif
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running, want finished");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset();
        RST       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        next_cycle();
        @(negedge ACLK);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %0b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== '0) $display("FAIL rst_data got %h want 0", out_data); else pass_cnt++;
        total_cnt++; if (count !== '0) $display("FAIL rst_count got %0d want 0", count); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %0b want 1", in_ready); else pass_cnt++;
        next_cycle();
        RST = 1'b0;
        next_cycle();
        @(negedge ACLK);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL post_rst_valid got %0b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== '0) $display("FAIL post_rst_data got %h want 0", out_data); else pass_cnt++;
        total_cnt++; if (count !== '0) $display("FAIL post_rst_count got %0d want 0", count); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready got %0b want 1", in_ready); else pass_cnt++;
        next_cycle();
    endtask

    // Words 1..8 pushed in cycles 0..7; word k leaves in cycle k+2.
    task automatic test_streaming();
        int exp_c;
        out_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            in_valid = (n < 8);
            in_data  = W'(n + 1);
            exp_c    = (n <= 3) ? n : ((n <= 8) ? 3 : 11 - n);
            @(negedge ACLK);
            total_cnt++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready n=%0d got %0b want 1", n, in_ready); else pass_cnt++;
            total_cnt++; if (out_valid !== (n >= 3 && n <= 10)) $display("FAIL stream_valid n=%0d got %0b want %0b", n, out_valid, (n >= 3 && n <= 10)); else pass_cnt++;
            if (n >= 3 && n <= 10) begin
                total_cnt++; if (out_data !== W'(n - 2)) $display("FAIL stream_data n=%0d got %h want %h", n, out_data, W'(n - 2)); else pass_cnt++;
            end
            total_cnt++; if (count !== CNT_W'(exp_c)) $display("FAIL stream_count n=%0d got %0d want %0d", n, count, exp_c); else pass_cnt++;
            next_cycle();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_stall();
        logic [W-1:0] in_tab  [10] = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hD, 32'hD, 0, 0, 0, 0};
        logic         iv_tab  [10] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        logic         or_tab  [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
        logic         rdy_tab [10] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
        logic         ov_tab  [10] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
        logic [W-1:0] od_tab  [10] = '{0, 0, 0, 32'hA, 32'hA, 32'hA, 32'hB, 32'hC, 32'hD, 0};
        int           c_tab   [10] = '{0, 1, 2, 3, 3, 3, 3, 2, 1, 0};
        for (int n = 0; n < 10; n++) begin
            in_valid  = iv_tab[n];
            in_data   = in_tab[n];
            out_ready = or_tab[n];
            @(negedge ACLK);
            total_cnt++; if (in_ready !== rdy_tab[n]) $display("FAIL stall_in_ready n=%0d got %0b want %0b", n, in_ready, rdy_tab[n]); else pass_cnt++;
            total_cnt++; if (out_valid !== ov_tab[n]) $display("FAIL stall_valid n=%0d got %0b want %0b", n, out_valid, ov_tab[n]); else pass_cnt++;
            if (ov_tab[n]) begin
                total_cnt++; if (out_data !== od_tab[n]) $display("FAIL stall_data n=%0d got %h want %h", n, out_data, od_tab[n]); else pass_cnt++;
            end
            total_cnt++; if (count !== CNT_W'(c_tab[n])) $display("FAIL stall_count n=%0d got %0d want %0d", n, count, c_tab[n]); else pass_cnt++;
            next_cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    // Fill with 0x100..0x102 under stall, then stream 0x103..0x108 with both sides active.
    task automatic test_full_passthrough();
        int exp_c;
        for (int n = 0; n < 13; n++) begin
            in_valid  = (n < 9);
            in_data   = W'(32'h100 + n);
            out_ready = (n >= 3);
            exp_c     = (n <= 3) ? n : ((n <= 9) ? 3 : 12 - n);
            @(negedge ACLK);
            total_cnt++; if (count !== CNT_W'(exp_c)) $display("FAIL full_count n=%0d got %0d want %0d", n, count, exp_c); else pass_cnt++;
            if (n >= 3 && n <= 8) begin
                total_cnt++; if (in_ready !== 1'b1) $display("FAIL full_in_ready n=%0d got %0b want 1", n, in_ready); else pass_cnt++;
            end
            total_cnt++; if (out_valid !== (n >= 3 && n <= 11)) $display("FAIL full_valid n=%0d got %0b want %0b", n, out_valid, (n >= 3 && n <= 11)); else pass_cnt++;
            if (n >= 3 && n <= 11) begin
                total_cnt++; if (out_data !== W'(32'h100 + n - 3)) $display("FAIL full_data n=%0d got %h want %h", n, out_data, W'(32'h100 + n - 3)); else pass_cnt++;
            end
            next_cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_bubble_collapse();
        logic         iv_tab [8] = '{1, 0, 0, 1, 0, 0, 0, 0};
        logic [W-1:0] in_tab [8] = '{32'h11, 0, 0, 32'h22, 0, 0, 0, 0};
        logic         or_tab [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
        logic         ov_tab [8] = '{0, 0, 0, 1, 1, 1, 1, 0};
        logic [W-1:0] od_tab [8] = '{0, 0, 0, 32'h11, 32'h11, 32'h11, 32'h22, 0};
        int           c_tab  [8] = '{0, 1, 1, 1, 2, 2, 1, 0};
        for (int n = 0; n < 8; n++) begin
            in_valid  = iv_tab[n];
            in_data   = in_tab[n];
            out_ready = or_tab[n];
            @(negedge ACLK);
            total_cnt++; if (in_ready !== 1'b1) $display("FAIL bubble_in_ready n=%0d got %0b want 1", n, in_ready); else pass_cnt++;
            total_cnt++; if (out_valid !== ov_tab[n]) $display("FAIL bubble_valid n=%0d got %0b want %0b", n, out_valid, ov_tab[n]); else pass_cnt++;
            if (ov_tab[n]) begin
                total_cnt++; if (out_data !== od_tab[n]) $display("FAIL bubble_data n=%0d got %h want %h", n, out_data, od_tab[n]); else pass_cnt++;
            end
            total_cnt++; if (count !== CNT_W'(c_tab[n])) $display("FAIL bubble_count n=%0d got %0d want %0d", n, count, c_tab[n]); else pass_cnt++;
            next_cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            in_valid = 1'b1;
            in_data  = W'(32'h51 + n);
            if (n < 3) next_cycle();
        end
        // Three words accepted, the fourth offered; assert reset between edges.
        #2;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL arst_pre_valid got %0b want 1", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 32'h51) $display("FAIL arst_pre_data got %h want 51", out_data); else pass_cnt++;
        RST = 1'b1;
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL arst_valid got %0b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== '0) $display("FAIL arst_data got %h want 0", out_data); else pass_cnt++;
        total_cnt++; if (count !== '0) $display("FAIL arst_count got %0d want 0", count); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL arst_in_ready got %0b want 1", in_ready); else pass_cnt++;
        in_valid = 1'b0;
        next_cycle();
        RST = 1'b0;
        next_cycle();
        @(negedge ACLK);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL arst_after_valid got %0b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (count !== '0) $display("FAIL arst_after_count got %0d want 0", count); else pass_cnt++;
        next_cycle();
        out_ready = 1'b0;
    endtask

`ifdef NBIT_PIPE_FLUSH_EN
    task automatic test_flush();
        flush     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h61;
        next_cycle();
        in_data   = 32'h62;
        next_cycle();
        in_data   = 32'h63;
        flush     = 1'b1;
        @(negedge ACLK);
        total_cnt++; if (count !== CNT_W'(2)) $display("FAIL flush_pre_count got %0d want 2", count); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got %0b want 0", in_ready); else pass_cnt++;
        next_cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge ACLK);
        total_cnt++; if (count !== '0) $display("FAIL flush_count got %0d want 0", count); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_valid got %0b want 0", out_valid); else pass_cnt++;
        next_cycle();
    endtask
`endif

    initial begin
`ifdef NBIT_PIPE_FLUSH_EN
        flush = 1'b0;
`endif
        test_reset();
        test_streaming();
        test_stall();
        test_full_passthrough();
        test_bubble_collapse();
        test_async_reset();
`ifdef NBIT_PIPE_FLUSH_EN
        test_flush();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
